// File: rtl/axi4_slave_addr_scheduler_if.sv
// Slave-side AXI4 address/response monitor bundle plus the command port toward the slave datapath.
// slave modport is the scheduler's view; master modport is the driving environment's view.
interface axi4_slave_addr_scheduler_if #(
    parameter int ADDR_WIDTH      = 32,
    parameter int ID_WIDTH        = 4,
    parameter int MAX_OUTSTANDING = 8
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    logic                  AWVALID;
    logic                  AWREADY;
    logic [ID_WIDTH-1:0]   AWID;
    logic [ADDR_WIDTH-1:0] AWADDR;
    logic [7:0]            AWLEN;
    logic [3:0]            AWQOS;

    logic                  ARVALID;
    logic                  ARREADY;
    logic [ID_WIDTH-1:0]   ARID;
    logic [ADDR_WIDTH-1:0] ARADDR;
    logic [7:0]            ARLEN;
    logic [3:0]            ARQOS;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ID_WIDTH-1:0]   cmd_id;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [7:0]            cmd_len;

    logic                  BVALID;
    logic                  BREADY;
    logic                  RVALID;
    logic                  RREADY;
    logic                  RLAST;

    logic [CW-1:0]         wr_outstanding;
    logic [CW-1:0]         rd_outstanding;
    logic                  proto_err;

    modport slave (
        input  AWVALID, AWID, AWADDR, AWLEN, AWQOS,
        output AWREADY,
        input  ARVALID, ARID, ARADDR, ARLEN, ARQOS,
        output ARREADY,
        output cmd_valid, cmd_write, cmd_id, cmd_addr, cmd_len,
        input  cmd_ready,
        input  BVALID, BREADY, RVALID, RREADY, RLAST,
        output wr_outstanding, rd_outstanding, proto_err
    );

    modport master (
        output AWVALID, AWID, AWADDR, AWLEN, AWQOS,
        input  AWREADY,
        output ARVALID, ARID, ARADDR, ARLEN, ARQOS,
        input  ARREADY,
        input  cmd_valid, cmd_write, cmd_id, cmd_addr, cmd_len,
        output cmd_ready,
        output BVALID, BREADY, RVALID, RREADY, RLAST,
        input  wr_outstanding, rd_outstanding, proto_err
    );
endinterface

// File: rtl/axi4_slave_addr_scheduler.sv
// Purpose: round-robin AW/AR arbiter onto one command port with per-direction outstanding limits.
// Latency: 1 cycle from AW/AR handshake to cmd_valid; one command per cycle sustained.
// Backpressure: cmd_valid && !cmd_ready holds cmd_* and withholds AWREADY/ARREADY.
// Optional: define AXI4_SCHED_QOS_EN to let higher AxQOS win when both channels are eligible.
module axi4_slave_addr_scheduler #(
    parameter int ADDR_WIDTH      = 32,
    parameter int ID_WIDTH        = 4,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                        ACLK,
    input  logic                        ARESETn,
    axi4_slave_addr_scheduler_if.slave  bus
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    typedef enum logic {
        DIR_READ  = 1'b0,
        DIR_WRITE = 1'b1
    } dir_t;

    typedef struct packed {
        logic                  write;
        logic [ID_WIDTH-1:0]   id;
        logic [ADDR_WIDTH-1:0] addr;
        logic [7:0]            len;
    } cmd_t;

    dir_t          last_grant;
    cmd_t          cmd_q;
    logic          cmd_vld;
    logic [CW-1:0] wr_cnt;
    logic [CW-1:0] rd_cnt;
    logic          perr;

    logic slot_free;
    logic w_elig;
    logic r_elig;
    logic prefer_w;
    logic grant_w;
    logic grant_r;
    logic wr_dec;
    logic rd_dec;

    always_comb begin
        slot_free = !cmd_vld || bus.cmd_ready;
        w_elig    = bus.AWVALID && (wr_cnt < MAX_CNT);
        r_elig    = bus.ARVALID && (rd_cnt < MAX_CNT);
`ifdef AXI4_SCHED_QOS_EN
        if (bus.AWQOS != bus.ARQOS) begin
            prefer_w = (bus.AWQOS > bus.ARQOS);
        end else begin
            prefer_w = (last_grant == DIR_READ);
        end
`else
        prefer_w = (last_grant == DIR_READ);
`endif
        // Readies stay low while reset is asserted even though slot_free is true then.
        grant_w = ARESETn && slot_free && w_elig && (!r_elig || prefer_w);
        grant_r = ARESETn && slot_free && r_elig && !grant_w;
        wr_dec  = bus.BVALID && bus.BREADY;
        rd_dec  = bus.RVALID && bus.RREADY && bus.RLAST;
    end

    function automatic logic [CW-1:0] cnt_next(input logic [CW-1:0] c, input logic inc, input logic dec);
        logic [CW-1:0] n;
        n = c;
        if (inc && !dec) begin
            n = c + 1'b1;
        end else if (dec && !inc && (c != '0)) begin
            n = c - 1'b1;
        end
        return n;
    endfunction

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            cmd_vld    <= 1'b0;
            cmd_q      <= '0;
            last_grant <= DIR_READ;
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            perr       <= 1'b0;
        end else begin
            if (grant_w) begin
                cmd_vld    <= 1'b1;
                cmd_q      <= cmd_t'{write: 1'b1, id: bus.AWID, addr: bus.AWADDR, len: bus.AWLEN};
                last_grant <= DIR_WRITE;
            end else if (grant_r) begin
                cmd_vld    <= 1'b1;
                cmd_q      <= cmd_t'{write: 1'b0, id: bus.ARID, addr: bus.ARADDR, len: bus.ARLEN};
                last_grant <= DIR_READ;
            end else if (bus.cmd_ready) begin
                cmd_vld <= 1'b0;
            end

            wr_cnt <= cnt_next(wr_cnt, grant_w, wr_dec);
            rd_cnt <= cnt_next(rd_cnt, grant_r, rd_dec);

            // A completion with nothing in flight is a protocol violation upstream.
            if ((wr_dec && !grant_w && (wr_cnt == '0)) ||
                (rd_dec && !grant_r && (rd_cnt == '0))) begin
                perr <= 1'b1;
            end
        end
    end

    assign bus.AWREADY        = grant_w;
    assign bus.ARREADY        = grant_r;
    assign bus.cmd_valid      = cmd_vld;
    assign bus.cmd_write      = cmd_q.write;
    assign bus.cmd_id         = cmd_q.id;
    assign bus.cmd_addr       = cmd_q.addr;
    assign bus.cmd_len        = cmd_q.len;
    assign bus.wr_outstanding = wr_cnt;
    assign bus.rd_outstanding = rd_cnt;
    assign bus.proto_err      = perr;
endmodule

// File: tb/tb_axi4_slave_addr_scheduler.sv
// Bench for axi4_slave_addr_scheduler: directed vector table, hand-written stall/reset sequences,
// and a randomized run against a queue-based model of in-flight transactions.
module tb_axi4_slave_addr_scheduler;
    localparam int AW   = 32;
    localparam int IW   = 4;
    localparam int MAXO = 3;

    logic ACLK    = 1'b0;
    logic ARESETn = 1'b0;
    always #5 ACLK = ~ACLK;

    axi4_slave_addr_scheduler_if #(.ADDR_WIDTH(AW), .ID_WIDTH(IW), .MAX_OUTSTANDING(MAXO)) bus ();

    axi4_slave_addr_scheduler #(.ADDR_WIDTH(AW), .ID_WIDTH(IW), .MAX_OUTSTANDING(MAXO)) dut (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .bus     (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.AWVALID = 1'b0; bus.AWID = '0; bus.AWADDR = '0; bus.AWLEN = '0; bus.AWQOS = '0;
        bus.ARVALID = 1'b0; bus.ARID = '0; bus.ARADDR = '0; bus.ARLEN = '0; bus.ARQOS = '0;
        bus.cmd_ready = 1'b0;
        bus.BVALID = 1'b0; bus.BREADY = 1'b1;
        bus.RVALID = 1'b0; bus.RREADY = 1'b1; bus.RLAST = 1'b0;
    endtask

    typedef struct {
        logic       aw, ar;
        logic [3:0] awq, arq;
        logic       rdy, b, r;
        logic       e_awr, e_arr, e_cv, e_cw;
        int         e_wr, e_rd;
        logic       e_perr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic aw, ar, input logic [3:0] awq, arq, input logic rdy, b, r,
                                input logic e_awr, e_arr, e_cv, e_cw, input int e_wr, e_rd, input logic e_perr);
        vec_t v;
        v.aw = aw; v.ar = ar; v.awq = awq; v.arq = arq; v.rdy = rdy; v.b = b; v.r = r;
        v.e_awr = e_awr; v.e_arr = e_arr; v.e_cv = e_cv; v.e_cw = e_cw;
        v.e_wr = e_wr; v.e_rd = e_rd; v.e_perr = e_perr;
        return v;
    endfunction

    // Reference model for the random run: in-flight IDs per direction and the pending command slot.
    typedef struct packed {
        logic          w;
        logic [IW-1:0] id;
        logic [AW-1:0] addr;
        logic [7:0]    len;
    } cmd_rec_t;

    logic [IW-1:0] wr_fly[$];
    logic [IW-1:0] rd_fly[$];
    cmd_rec_t      pend[$];
    bit            m_last_w;
    bit            m_perr;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] held_addr;
        int            winner;
        bit            free, can_w, can_r;

        // ---------------- reset state, requests held high ----------------
        drive_idle();
        bus.AWVALID = 1'b1; bus.ARVALID = 1'b1; bus.cmd_ready = 1'b1;
        repeat (2) @(negedge ACLK);
        chk("rst awready", bus.AWREADY, 0);
        chk("rst arready", bus.ARREADY, 0);
        chk("rst cmd_valid", bus.cmd_valid, 0);
        chk("rst cmd_addr", bus.cmd_addr, 0);
        chk("rst cmd_id", bus.cmd_id, 0);
        chk("rst cmd_len", bus.cmd_len, 0);
        chk("rst wr_out", bus.wr_outstanding, 0);
        chk("rst rd_out", bus.rd_outstanding, 0);
        chk("rst proto_err", bus.proto_err, 0);

        // ---------------- vector table ----------------
        //           aw ar awq arq rdy b r | awr arr cv cw wr rd perr
        tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, 1, 0, 1, 1, 1, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 1, 1, 0, 1, 1, 0));
        tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, 1, 0, 1, 1, 2, 1, 0));
        tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 1, 1, 0, 2, 2, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 1, 0, 1, 1, 2, 2, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 1, 0, 1, 1, 3, 2, 0));
        tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 1, 1, 0, 3, 3, 0));
        tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 3, 3, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 2, 3, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 1, 0, 1, 1, 3, 3, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 3, 2, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 3, 2, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 1, 1, 0, 3, 3, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 2, 2, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1));
`ifdef AXI4_SCHED_QOS_EN
        tbl.push_back(mk(1, 1, 2, 9, 1, 0, 0, 0, 1, 1, 0, 0, 1, 1));
        tbl.push_back(mk(1, 1, 2, 9, 1, 0, 0, 0, 1, 1, 0, 0, 2, 1));
        tbl.push_back(mk(1, 1, 5, 5, 1, 0, 0, 1, 0, 1, 1, 1, 2, 1));
        tbl.push_back(mk(1, 1, 5, 5, 1, 0, 0, 0, 1, 1, 0, 1, 3, 1));
`else
        tbl.push_back(mk(1, 1, 2, 9, 1, 0, 0, 1, 0, 1, 1, 1, 0, 1));
        tbl.push_back(mk(1, 1, 2, 9, 1, 0, 0, 0, 1, 1, 0, 1, 1, 1));
        tbl.push_back(mk(1, 1, 5, 5, 1, 0, 0, 1, 0, 1, 1, 2, 1, 1));
        tbl.push_back(mk(1, 1, 5, 5, 1, 0, 0, 0, 1, 1, 0, 2, 2, 1));
`endif

        @(posedge ACLK); #1;
        ARESETn = 1'b1;
        foreach (tbl[i]) begin
            bus.AWVALID = tbl[i].aw; bus.ARVALID = tbl[i].ar;
            bus.AWQOS = tbl[i].awq;  bus.ARQOS = tbl[i].arq;
            bus.AWADDR = 32'h0000_1000 + 32'(i); bus.ARADDR = 32'h0000_2000 + 32'(i);
            bus.AWID = 4'(i); bus.ARID = 4'(i + 8);
            bus.cmd_ready = tbl[i].rdy;
            bus.BVALID = tbl[i].b; bus.RVALID = tbl[i].r; bus.RLAST = tbl[i].r;
            @(negedge ACLK);
            chk($sformatf("v%0d awready", i), bus.AWREADY, tbl[i].e_awr);
            chk($sformatf("v%0d arready", i), bus.ARREADY, tbl[i].e_arr);
            @(posedge ACLK); #1;
            chk($sformatf("v%0d cmd_valid", i), bus.cmd_valid, tbl[i].e_cv);
            chk($sformatf("v%0d cmd_write", i), bus.cmd_write, tbl[i].e_cw);
            chk($sformatf("v%0d wr_out", i), bus.wr_outstanding, 64'(tbl[i].e_wr));
            chk($sformatf("v%0d rd_out", i), bus.rd_outstanding, 64'(tbl[i].e_rd));
            chk($sformatf("v%0d proto_err", i), bus.proto_err, tbl[i].e_perr);
            if (tbl[i].e_awr || tbl[i].e_arr)
                chk($sformatf("v%0d cmd_addr", i), bus.cmd_addr,
                    tbl[i].e_awr ? 64'(32'h0000_1000 + 32'(i)) : 64'(32'h0000_2000 + 32'(i)));
        end

        // ---------------- reset mid-command with counts at 3 ----------------
        drive_idle();
        ARESETn = 1'b0;
        @(posedge ACLK); #1;
        ARESETn = 1'b1;
        bus.BVALID = 1'b1;                       // completion with nothing in flight
        @(posedge ACLK); #1;
        bus.BVALID = 1'b0;
        bus.AWVALID = 1'b1; bus.ARVALID = 1'b1; bus.cmd_ready = 1'b1;
        repeat (6) @(posedge ACLK);
        #1;
        chk("pre-rst wr_out", bus.wr_outstanding, 3);
        chk("pre-rst rd_out", bus.rd_outstanding, 3);
        chk("pre-rst cmd_valid", bus.cmd_valid, 1);
        chk("pre-rst proto_err", bus.proto_err, 1);
        #1 ARESETn = 1'b0;
        #1;
        chk("mid-rst cmd_valid", bus.cmd_valid, 0);
        chk("mid-rst wr_out", bus.wr_outstanding, 0);
        chk("mid-rst rd_out", bus.rd_outstanding, 0);
        chk("mid-rst proto_err", bus.proto_err, 0);
        chk("mid-rst awready", bus.AWREADY, 0);

        // ---------------- command stall for 5 cycles ----------------
        drive_idle();
        @(posedge ACLK); #1;
        ARESETn = 1'b1;
        bus.AWVALID = 1'b1; bus.AWID = 4'd7; bus.AWADDR = 32'hDEAD_0000; bus.AWLEN = 8'd15;
        @(negedge ACLK);
        chk("stall first awready", bus.AWREADY, 1);
        @(posedge ACLK); #1;
        held_addr = bus.AWADDR;
        bus.ARVALID = 1'b1; bus.ARID = 4'd3; bus.ARADDR = 32'hBEEF_0040; bus.ARLEN = 8'd2;
        for (int k = 0; k < 5; k++) begin
            bus.AWADDR = 32'hDEAD_0100 + 32'(k); bus.AWID = 4'(k);
            @(negedge ACLK);
            chk($sformatf("stall%0d awready", k), bus.AWREADY, 0);
            chk($sformatf("stall%0d arready", k), bus.ARREADY, 0);
            @(posedge ACLK); #1;
            chk($sformatf("stall%0d cmd_valid", k), bus.cmd_valid, 1);
            chk($sformatf("stall%0d cmd_addr", k), bus.cmd_addr, held_addr);
            chk($sformatf("stall%0d cmd_id", k), bus.cmd_id, 7);
            chk($sformatf("stall%0d cmd_len", k), bus.cmd_len, 15);
        end
        bus.cmd_ready = 1'b1;
        @(negedge ACLK);
        chk("resume arready", bus.ARREADY, 1);
        chk("resume awready", bus.AWREADY, 0);
        @(posedge ACLK); #1;
        chk("resume cmd_write", bus.cmd_write, 0);
        chk("resume cmd_addr", bus.cmd_addr, 32'hBEEF_0040);

        // ---------------- randomized run against the reference model ----------------
        drive_idle();
        ARESETn = 1'b0;
        @(posedge ACLK); #1;
        ARESETn = 1'b1;
        wr_fly.delete(); rd_fly.delete(); pend.delete();
        m_last_w = 1'b0; m_perr = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bus.AWVALID = ($urandom_range(0, 99) < 60); bus.AWID = 4'($urandom);
            bus.AWADDR = $urandom; bus.AWLEN = 8'($urandom); bus.AWQOS = 4'($urandom_range(0, 3));
            bus.ARVALID = ($urandom_range(0, 99) < 60); bus.ARID = 4'($urandom);
            bus.ARADDR = $urandom; bus.ARLEN = 8'($urandom); bus.ARQOS = 4'($urandom_range(0, 3));
            bus.cmd_ready = ($urandom_range(0, 99) < 70);
            bus.BVALID = ($urandom_range(0, 99) < 25); bus.BREADY = ($urandom_range(0, 99) < 80);
            bus.RVALID = ($urandom_range(0, 99) < 35); bus.RREADY = ($urandom_range(0, 99) < 80);
            bus.RLAST = ($urandom_range(0, 99) < 60);
            @(negedge ACLK);
            free  = (pend.size() == 0) || bus.cmd_ready;
            can_w = bus.AWVALID && (wr_fly.size() < MAXO);
            can_r = bus.ARVALID && (rd_fly.size() < MAXO);
            winner = 0;
            if (free) begin
                if (can_w && can_r) begin
                    winner = m_last_w ? 2 : 1;
`ifdef AXI4_SCHED_QOS_EN
                    if (bus.AWQOS > bus.ARQOS) winner = 1;
                    else if (bus.ARQOS > bus.AWQOS) winner = 2;
`endif
                end else if (can_w) winner = 1;
                else if (can_r) winner = 2;
            end
            chk($sformatf("rnd%0d awready", cyc), bus.AWREADY, winner == 1);
            chk($sformatf("rnd%0d arready", cyc), bus.ARREADY, winner == 2);
            if (free && pend.size() != 0) void'(pend.pop_front());
            if (winner == 1) begin
                wr_fly.push_back(bus.AWID);
                pend.push_back(cmd_rec_t'{w: 1'b1, id: bus.AWID, addr: bus.AWADDR, len: bus.AWLEN});
                m_last_w = 1'b1;
            end else if (winner == 2) begin
                rd_fly.push_back(bus.ARID);
                pend.push_back(cmd_rec_t'{w: 1'b0, id: bus.ARID, addr: bus.ARADDR, len: bus.ARLEN});
                m_last_w = 1'b0;
            end
            if (bus.BVALID && bus.BREADY) begin
                if (wr_fly.size() == 0) m_perr = 1'b1;
                else void'(wr_fly.pop_front());
            end
            if (bus.RVALID && bus.RREADY && bus.RLAST) begin
                if (rd_fly.size() == 0) m_perr = 1'b1;
                else void'(rd_fly.pop_front());
            end
            @(posedge ACLK); #1;
            chk($sformatf("rnd%0d cmd_valid", cyc), bus.cmd_valid, pend.size() != 0);
            chk($sformatf("rnd%0d wr_out", cyc), bus.wr_outstanding, 64'(wr_fly.size()));
            chk($sformatf("rnd%0d rd_out", cyc), bus.rd_outstanding, 64'(rd_fly.size()));
            chk($sformatf("rnd%0d proto_err", cyc), bus.proto_err, m_perr);
            if (pend.size() != 0) begin
                chk($sformatf("rnd%0d cmd_write", cyc), bus.cmd_write, pend[0].w);
                chk($sformatf("rnd%0d cmd_id", cyc), bus.cmd_id, pend[0].id);
                chk($sformatf("rnd%0d cmd_addr", cyc), bus.cmd_addr, pend[0].addr);
                chk($sformatf("rnd%0d cmd_len", cyc), bus.cmd_len, pend[0].len);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
